// File: rtl/vram_scheduler.sv
// vram_scheduler: 8-phase time-slot arbiter sharing the char and font RAMs between
// the text display pipeline, the CPU bus and a fill/scroll engine.
module vram_scheduler #(
  parameter int COLS    = 80,
  parameter int ROWS    = 30,
  parameter int CHAR_AW = 12,
  parameter int FONT_AW = 11
) (
  input  logic               clk,
  input  logic               reset_button,
  input  logic [9:0]         pix_x,
  input  logic [9:0]         pix_y,
  output logic [CHAR_AW-1:0] char_addr,
  output logic               char_we,
  output logic [7:0]         char_wdata,
  input  logic [7:0]         char_rdata,
  output logic [FONT_AW-1:0] font_addr,
  output logic               font_we,
  output logic [7:0]         font_wdata,
  input  logic [7:0]         font_rdata,
  output logic [7:0]         disp_bitmap,
  output logic               disp_hilite,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic               cpu_font,
  input  logic [11:0]        cpu_addr,
  input  logic [7:0]         cpu_wdata,
  output logic [7:0]         cpu_rdata,
  output logic               cpu_ack,
  input  logic               eng_start,
  input  logic               eng_op,
  input  logic [7:0]         eng_fill,
  output logic               eng_busy,
  output logic               eng_done
);
  typedef enum logic [2:0] {IDLE, FILL, SCR_RD, SCR_WR, DONE} eng_state_e;
  localparam logic [CHAR_AW-1:0] LAST    = CHAR_AW'(COLS * ROWS - 1);
  localparam logic [CHAR_AW-1:0] SCR_END = CHAR_AW'(COLS * (ROWS - 1));
  localparam logic [CHAR_AW-1:0] COLS_W  = CHAR_AW'(COLS);
  eng_state_e state_q, state_d;
  logic [CHAR_AW-1:0] idx_q, idx_d, disp_addr;
  logic [7:0] fill_q, fill_d, scr_q, scr_d, bitmap_q, bitmap_d, rdata_q, rdata_d, scr_byte;
  logic run_q, hilite_q, hilite_d, disp_hilite_q, disp_hilite_d;
  logic ack_q, ack_d, ack_font_q, ack_font_d, eng_rd_q, eng_rd_d;
  logic [2:0] p;
  logic grant, cpu_go, cpu_char, eng_act, eng_go;
  always_comb begin
    p = pix_x[2:0];
    grant = run_q && p >= 3'd2 && p <= 3'd6;
    cpu_go = grant && cpu_req && !ack_q;
    cpu_char = cpu_go && !cpu_font;
    eng_act = state_q inside {FILL, SCR_RD, SCR_WR};
    eng_go = grant && eng_act && !cpu_char;
    // scroll write may land right after its read, before the byte is latched
    scr_byte = eng_rd_q ? char_rdata : scr_q;
    disp_addr = CHAR_AW'(pix_x[9:3]) + COLS_W * CHAR_AW'(pix_y[9:4]);
    char_addr = '0;
    char_we = 1'b0;
    char_wdata = '0;
    if (run_q && p == 3'd0) char_addr = disp_addr;
    else if (cpu_char) begin
      char_addr = cpu_addr[CHAR_AW-1:0];
      char_we = cpu_we;
      char_wdata = cpu_wdata;
    end else if (eng_go) begin
      char_addr = state_q == SCR_RD ? idx_q + COLS_W : idx_q;
      char_we = state_q != SCR_RD;
      char_wdata = state_q == SCR_WR ? scr_byte : fill_q;
    end
    font_addr = '0;
    font_we = 1'b0;
    font_wdata = '0;
    if (run_q && p == 3'd1) font_addr = FONT_AW'({char_rdata[6:0], pix_y[3:0]});
    else if (cpu_go && cpu_font) begin
      font_addr = cpu_addr[FONT_AW-1:0];
      font_we = cpu_we;
      font_wdata = cpu_wdata;
    end
    hilite_d = run_q && p == 3'd1 ? char_rdata[7] : hilite_q;
    bitmap_d = run_q && p == 3'd2 ? font_rdata : bitmap_q;
    disp_hilite_d = run_q && p == 3'd2 ? hilite_q : disp_hilite_q;
    ack_d = cpu_go;
    ack_font_d = cpu_go && cpu_font;
    cpu_rdata = ack_q ? (ack_font_q ? font_rdata : char_rdata) : rdata_q;
    rdata_d = cpu_rdata;
    cpu_ack = ack_q;
    disp_bitmap = bitmap_q;
    disp_hilite = disp_hilite_q;
    eng_rd_d = eng_go && state_q == SCR_RD;
    scr_d = scr_byte;
    eng_busy = eng_act;
    eng_done = state_q == DONE;
    state_d = state_q;
    idx_d = idx_q;
    fill_d = fill_q;
    case (state_q)
      IDLE: if (eng_start) begin
        state_d = eng_op ? SCR_RD : FILL;
        idx_d = '0;
        fill_d = eng_fill;
      end
      FILL: if (eng_go) begin
        state_d = idx_q == LAST ? DONE : FILL;
        idx_d = idx_q + CHAR_AW'(1);
      end
      SCR_RD: if (eng_go) state_d = SCR_WR;
      SCR_WR: if (eng_go) begin
        idx_d = idx_q + CHAR_AW'(1);
        state_d = idx_d == SCR_END ? FILL : SCR_RD;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_button)
    if (!reset_button) begin
      run_q <= 1'b0;
      state_q <= IDLE;
      idx_q <= '0;
      fill_q <= '0;
      scr_q <= '0;
      eng_rd_q <= 1'b0;
      hilite_q <= 1'b0;
      bitmap_q <= '0;
      disp_hilite_q <= 1'b0;
      ack_q <= 1'b0;
      ack_font_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      run_q <= 1'b1;
      state_q <= state_d;
      idx_q <= idx_d;
      fill_q <= fill_d;
      scr_q <= scr_d;
      eng_rd_q <= eng_rd_d;
      hilite_q <= hilite_d;
      bitmap_q <= bitmap_d;
      disp_hilite_q <= disp_hilite_d;
      ack_q <= ack_d;
      ack_font_q <= ack_font_d;
      rdata_q <= rdata_d;
    end
endmodule

// File: doc/vram_scheduler.md
Name: vram_scheduler

Overview:
- Time-slot scheduler for the single-port character RAM (8-bit, 80x30 text) and font RAM (8-bit, 8x16 glyphs) shared by three users.
- Users: the VGA text pixel pipeline, the CPU bus, and a built-in fill/scroll engine.
- Every 8-pixel character cell is one 8-cycle frame keyed on pix_x[2:0]. Display fetches own fixed phases; CPU and engine accesses are granted in the remaining phases.
- Sits between simple_480p/FemtoRV32 and the two RAM arrays. It replaces the fixed CPU wait-for-phase-3 rule with an acknowledged request handshake.

Parameters:
- COLS, 80, text columns
- ROWS, 30, text rows; COLS*ROWS must be <= 2**CHAR_AW
- CHAR_AW, 12, character RAM address width
- FONT_AW, 11, font RAM address width

Ports:
- clk  in  1  pixel clock, 25 MHz
- reset_button  in  1  asynchronous, active-low reset
- pix_x  in  10  current pixel column from the sync generator
- pix_y  in  10  current pixel row from the sync generator
- char_addr  out  CHAR_AW  character RAM address
- char_we  out  1  character RAM write enable
- char_wdata  out  8  character RAM write data
- char_rdata  in  8  character RAM read data, valid 1 cycle after address
- font_addr  out  FONT_AW  font RAM address
- font_we  out  1  font RAM write enable
- font_wdata  out  8  font RAM write data
- font_rdata  in  8  font RAM read data, valid 1 cycle after address
- disp_bitmap  out  8  glyph row for the current cell, MSB = leftmost pixel
- disp_hilite  out  1  char bit 7 of the current cell
- cpu_req  in  1  CPU access request, held high until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_font  in  1  1 = font RAM, 0 = character RAM
- cpu_addr  in  12  byte address
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  CPU read data, valid while cpu_ack is high
- cpu_ack  out  1  one-cycle completion pulse
- eng_start  in  1  one-cycle engine start pulse
- eng_op  in  1  0 = fill screen, 1 = scroll up one row
- eng_fill  in  8  fill byte, captured at start
- eng_busy  out  1  engine running
- eng_done  out  1  one-cycle completion pulse

Behaviour:
- Reset: async on reset_button low. All outputs are 0, the engine is IDLE, and any pending grant is dropped. No ack or done pulse is issued for an interrupted operation. Memory contents may be partially updated.
- Phase p = pix_x[2:0]. The schedule runs unconditionally, including during blanking.
- Phase 0: char_addr = pix_x[9:3] + COLS*pix_y[9:4], char_we = 0.
- Phase 1: font_addr = {char_rdata[6:0], pix_y[3:0]}, font_we = 0. hilite_d is latched from char_rdata[7].
- Phase 2: disp_bitmap and disp_hilite are loaded from font_rdata and hilite_d. They hold until the next phase 2. Display latency from phase-0 address to disp_bitmap valid is 3 cycles.
- Grant phases are 2..6 only, so read data returns by phase 7 and never collides with display data. Phases 7 and 0/1 carry no grant.
- CPU has priority over the engine on the same RAM.
- The engine only touches character RAM. A CPU font access and an engine char access may be granted in the same cycle.
- CPU transaction:
  - Issued in the first grant phase with cpu_req high and no outstanding transaction.
  - cpu_ack pulses on the following cycle. For reads, cpu_rdata is the RAM data on that cycle and holds until the next ack.
  - Worst-case request-to-ack latency is 8 cycles.
  - cpu_req must drop, or present a new request, after ack. A still-high request after ack is treated as a new transaction.
  - Address truncation: the character RAM uses cpu_addr[CHAR_AW-1:0] and the font RAM uses cpu_addr[FONT_AW-1:0].
- Engine FSM:
  - IDLE: eng_start captures eng_op and eng_fill, sets eng_busy, and clears idx to 0. For op 0 it goes to FILL; for op 1 it goes to SCR_RD. eng_start is ignored while busy.
  - FILL: each char grant writes the fill byte to idx, then idx++. At idx = COLS*ROWS-1 the write is followed by DONE.
  - SCR_RD: each char grant reads idx+COLS, then goes to SCR_WR.
  - SCR_WR: each char grant writes the latched read byte to idx, then idx++. At idx = COLS*(ROWS-1) it goes to FILL, continuing from that idx (bottom row blanked). Otherwise it returns to SCR_RD.
  - DONE: eng_done pulses 1 cycle, eng_busy clears, and the FSM returns to IDLE.
- A CPU write colliding with the engine on the same address is ordered by grant order. The scheduler provides no coherence guarantee.

Test Plan:
- Preload char[0] = 0x41 and font[0x410] = 0x3C; sweep pix_x = 0..7 at pix_y = 0 -> disp_bitmap = 0x3C and disp_hilite = 0 from the cycle after phase 2.
- Set char[81] = 0xC2 and pix_y = 17 (row 1, font row 1); sweep pix_x = 8..15 -> font_addr = 0x421 at pix_x = 9, disp_hilite = 1 after pix_x = 10.
- Raise cpu_req for a read of char 0x005 at phase 7 -> issue at the next phase 2, cpu_ack 4 cycles after request, cpu_rdata = stored byte.
- Start fill with eng_fill = 0x20 -> eng_busy for 2400 writes (480 cells x 5), eng_done pulses once, and char[0..2399] = 0x20.
- Load row r with byte r, then start scroll with eng_fill = 0x00 -> char[80*k] = k+1 for k < 29, row 29 = 0x00. Concurrent CPU font writes are each acked within 8 cycles.
- Assert reset_button low mid-scroll -> eng_busy = 0 immediately, no eng_done pulse, and a new eng_start after reset is accepted.
